// File: rtl/msgpass_rd_sched_if.sv
// Handshake and status bundle between the layer control / memory-share
// controller side (master) and the read scheduler (slave).
interface msgpass_rd_sched_if #(
    parameter int ADDR_WIDTH      = 3,
    parameter int DRC_NUM         = 1,
    parameter int STALL_CNT_WIDTH = 8
);
    logic                       start_i;
    logic                       stop_i;
    logic [ADDR_WIDTH-1:0]      base_addr_i;
    logic [ADDR_WIDTH-1:0]      last_addr_i;
    logic [DRC_NUM-1:0]         is_drc_i;
    logic [ADDR_WIDTH-1:0]      raddr_o;
    logic                       rd_issue_o;
    logic                       rdata_valid_o;
    logic                       rdata_last_o;
    logic                       busy_o;
    logic                       done_o;
    logic                       aborted_o;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_o;
    logic                       hold_err_o;

    modport master (
        output start_i, stop_i, base_addr_i, last_addr_i, is_drc_i,
        input  raddr_o, rd_issue_o, rdata_valid_o, rdata_last_o,
               busy_o, done_o, aborted_o, stall_cnt_o, hold_err_o
    );

    modport slave (
        input  start_i, stop_i, base_addr_i, last_addr_i, is_drc_i,
        output raddr_o, rd_issue_o, rdata_valid_o, rdata_last_o,
               busy_o, done_o, aborted_o, stall_cnt_o, hold_err_o
    );
endinterface

// File: rtl/msgpass_rd_sched.sv
// Read scheduler for message-pass buffer port A: walks a programmed address
// window one address per cycle, re-issues the current address while the
// memory-share controller flags a conflict, and produces read-data
// valid/last strobes aligned to the buffer read latency.
module msgpass_rd_sched #(
    parameter int ADDR_WIDTH      = 3,
    parameter int DRC_NUM         = 1,
    parameter int RD_LAT          = 1,
    parameter int MAX_HOLD        = 3,
    parameter int STALL_CNT_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    msgpass_rd_sched_if.slave     bus
);
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam int DC_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        raddr;
    logic [ADDR_WIDTH-1:0]        last_q;
    logic                         rd_issue;
    logic                         busy;
    logic                         done;
    logic                         aborted;
    logic                         abort_q;
    logic [STALL_CNT_WIDTH-1:0]   stall_cnt;
    logic                         hold_err;
    logic [HC_W-1:0]              hold_cnt;
    logic [DC_W-1:0]              drain_cnt;
    logic [RD_LAT-1:0]            valid_sr;
    logic [RD_LAT-1:0]            last_sr;

    logic drc_any;
    logic at_last;
    logic hold_full;
    logic last_fire;

    // Saturating increment so a long conflict storm never wraps the counter.
    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign drc_any   = |bus.is_drc_i;
    assign at_last   = (raddr == last_q);
    assign hold_full = (hold_cnt == HC_W'(MAX_HOLD));

    // The issue of the last address that actually moves the window forward;
    // held repeats and aborted issues never mark the last beat.
    assign last_fire = at_last && !bus.stop_i &&
                       ((state == S_READ && !drc_any) ||
                        (state == S_HOLD && (!drc_any || hold_full)));

    // Control FSM with registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            raddr     <= '0;
            last_q    <= '0;
            rd_issue  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            abort_q   <= 1'b0;
            stall_cnt <= '0;
            hold_err  <= 1'b0;
            hold_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        raddr     <= bus.base_addr_i;
                        last_q    <= bus.last_addr_i;
                        stall_cnt <= '0;
                        hold_err  <= 1'b0;
                        abort_q   <= 1'b0;
                        aborted   <= 1'b0;
                        rd_issue  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ, S_HOLD: begin
                    if (bus.stop_i) begin
                        abort_q   <= 1'b1;
                        rd_issue  <= 1'b0;
                        drain_cnt <= DC_W'(1);
                        state     <= S_DRAIN;
                    end else if (drc_any && (state == S_READ || !hold_full)) begin
                        hold_cnt  <= (state == S_READ) ? HC_W'(1) : hold_cnt + 1'b1;
                        stall_cnt <= sat_inc(stall_cnt);
                        state     <= S_HOLD;
                    end else begin
                        // Normal advance, or a forced one when the hold limit is hit.
                        if (drc_any) begin
                            hold_err <= 1'b1;
                        end
                        if (at_last) begin
                            rd_issue  <= 1'b0;
                            drain_cnt <= DC_W'(1);
                            state     <= S_DRAIN;
                        end else begin
                            raddr <= raddr + 1'b1;
                            state <= S_READ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DC_W'(RD_LAT)) begin
                        done    <= 1'b1;
                        aborted <= abort_q;
                        state   <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-latency pipeline: valid and last travel with the buffer access.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= rd_issue;
            last_sr[0]  <= last_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign bus.raddr_o       = raddr;
    assign bus.rd_issue_o    = rd_issue;
    assign bus.rdata_valid_o = valid_sr[RD_LAT-1];
    assign bus.rdata_last_o  = last_sr[RD_LAT-1];
    assign bus.busy_o        = busy;
    assign bus.done_o        = done;
    assign bus.aborted_o     = aborted;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.hold_err_o    = hold_err;
endmodule

// File: tb/tb_msgpass_rd_sched.sv
// Scoreboard bench for msgpass_rd_sched: expected issues, data beats and
// done timing are queued from a small window model when a window is started
// and compared cycle by cycle as the scheduler produces them.
module tb_msgpass_rd_sched;
    localparam int AW       = 3;
    localparam int RD_LAT   = 1;
    localparam int MAX_HOLD = 3;
    localparam int SW       = 8;

    logic sys_clk = 1'b0;
    logic rst;

    msgpass_rd_sched_if #(.ADDR_WIDTH(AW), .DRC_NUM(1), .STALL_CNT_WIDTH(SW)) bus ();

    msgpass_rd_sched #(
        .ADDR_WIDTH(AW), .DRC_NUM(1), .RD_LAT(RD_LAT),
        .MAX_HOLD(MAX_HOLD), .STALL_CNT_WIDTH(SW)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t iss_q[$];
    exp_t dat_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   exp_done  = -1;
    int   exp_abort = 0;
    int   done_cnt  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
            chk("iss_missing", cyc, iss_q[0].cyc);
            void'(iss_q.pop_front());
        end
        while (dat_q.size() > 0 && dat_q[0].cyc < cyc) begin
            chk("dat_missing", cyc, dat_q[0].cyc);
            void'(dat_q.pop_front());
        end
        if (bus.rd_issue_o) begin
            if (iss_q.size() == 0) chk("iss_extra", 1, 0);
            else begin
                e = iss_q.pop_front();
                chk("iss_cyc", cyc, e.cyc);
                chk("iss_addr", int'(bus.raddr_o), e.val);
            end
        end
        if (bus.rdata_valid_o) begin
            if (dat_q.size() == 0) chk("dat_extra", 1, 0);
            else begin
                e = dat_q.pop_front();
                chk("dat_cyc", cyc, e.cyc);
                chk("dat_last", int'(bus.rdata_last_o), e.val);
            end
        end else if (bus.rdata_last_o) begin
            chk("last_without_valid", 1, 0);
        end
        if (bus.done_o) begin
            done_cnt++;
            chk("done_cyc", cyc, exp_done);
            chk("aborted", int'(bus.aborted_o), exp_abort);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        cyc++;
        #1;
        monitor();
    endtask

    // Window model: start seen at cycle s; hold_extra repeats at hold_addr;
    // a stop at stop_addr ends the window after that single issue.
    task automatic push_win(input int s, input int base, input int last,
                            input int hold_addr, input int hold_extra, input int stop_addr);
        int c;
        int a;
        int n;
        c = s + 1;
        a = base;
        exp_abort = 0;
        for (int k = 0; k < (1 << AW); k++) begin
            if (a == stop_addr) begin
                iss_q.push_back('{cyc: c, val: a});
                dat_q.push_back('{cyc: c + RD_LAT, val: 0});
                exp_abort = 1;
                c++;
                break;
            end
            n = (a == hold_addr) ? 1 + hold_extra : 1;
            for (int i = 0; i < n; i++) begin
                iss_q.push_back('{cyc: c, val: a});
                dat_q.push_back('{cyc: c + RD_LAT, val: (a == last && i == n - 1) ? 1 : 0});
                c++;
            end
            if (a == last) break;
            a = (a + 1) % (1 << AW);
        end
        exp_done = (c - 1) + RD_LAT + 1;
    endtask

    task automatic run_window(input int base, input int last, input int hold_addr,
                              input int hold_extra, input int stop_addr,
                              input int drc_rel, input int drc_len, input int stop_rel,
                              input int exp_stall, input int exp_herr);
        int s;
        int d0;
        s  = cyc;
        d0 = done_cnt;
        bus.base_addr_i = AW'(base);
        bus.last_addr_i = AW'(last);
        bus.start_i     = 1'b1;
        push_win(s, base, last, hold_addr, hold_extra, stop_addr);
        for (int k = 0; k < 100; k++) begin
            step();
            bus.start_i  = (cyc == s + 3);
            bus.is_drc_i = (cyc >= s + drc_rel && cyc < s + drc_rel + drc_len) ? 1'b1 : 1'b0;
            bus.stop_i   = (cyc == s + stop_rel);
            if (cyc == s + 1) begin
                chk("busy_start", int'(bus.busy_o), 1);
                chk("herr_cleared", int'(bus.hold_err_o), 0);
            end
            if (cyc == exp_done + 1) break;
        end
        bus.start_i  = 1'b0;
        bus.is_drc_i = 1'b0;
        bus.stop_i   = 1'b0;
        chk("window_end_cyc", cyc, exp_done + 1);
        chk("busy_end", int'(bus.busy_o), 0);
        chk("done_count", done_cnt - d0, 1);
        chk("stall_cnt", int'(bus.stall_cnt_o), exp_stall);
        chk("hold_err", int'(bus.hold_err_o), exp_herr);
        chk("iss_left", iss_q.size(), 0);
        chk("dat_left", dat_q.size(), 0);
    endtask

    initial begin
        int s;
        int d0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.stop_i      = 1'b0;
        bus.base_addr_i = '0;
        bus.last_addr_i = '0;
        bus.is_drc_i    = '0;
        step();
        step();
        chk("rst_raddr", int'(bus.raddr_o), 0);
        chk("rst_issue", int'(bus.rd_issue_o), 0);
        chk("rst_valid", int'(bus.rdata_valid_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_stall", int'(bus.stall_cnt_o), 0);
        rst = 1'b0;
        while (cyc < 10) step();

        // Plain window 0..4, start at cycle 10.
        run_window(0, 4, -1, 0, -1, 0, 0, -1, 0, 0);
        step();
        // One conflict cycle at address 1.
        run_window(0, 4, 1, 1, -1, 2, 1, -1, 1, 0);
        step();
        // Conflict held on address 2 until the hold limit forces an advance.
        run_window(0, 4, 2, MAX_HOLD, -1, 3, MAX_HOLD + 1, -1, MAX_HOLD, 1);
        step();
        chk("herr_sticky", int'(bus.hold_err_o), 1);
        // Stop while idle must not disturb anything.
        bus.stop_i = 1'b1;
        step();
        bus.stop_i = 1'b0;
        chk("idle_stop_busy", int'(bus.busy_o), 0);
        step();
        // Window wrapping across the top of the buffer.
        run_window(6, 1, -1, 0, -1, 0, 0, -1, 0, 0);
        step();
        // Single-address window.
        run_window(5, 5, -1, 0, -1, 0, 0, -1, 0, 0);
        step();
        // Stop at address 2 together with a conflict: stop wins.
        run_window(0, 4, -1, 0, 2, 3, 1, 3, 0, 0);
        step();

        // Reset in the middle of a window (hold at 1 makes stall non-zero).
        s  = cyc;
        d0 = done_cnt;
        bus.base_addr_i = AW'(0);
        bus.last_addr_i = AW'(3);
        bus.start_i     = 1'b1;
        push_win(s, 0, 3, 1, 1, -1);
        for (int k = 0; k < 20; k++) begin
            step();
            bus.start_i  = 1'b0;
            bus.is_drc_i = (cyc == s + 2) ? 1'b1 : 1'b0;
            if (cyc == s + 5) break;
        end
        chk("pre_rst_raddr", int'(bus.raddr_o), 3);
        chk("pre_rst_stall", int'(bus.stall_cnt_o), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_raddr", int'(bus.raddr_o), 0);
        chk("mid_rst_issue", int'(bus.rd_issue_o), 0);
        chk("mid_rst_valid", int'(bus.rdata_valid_o), 0);
        chk("mid_rst_last", int'(bus.rdata_last_o), 0);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        chk("mid_rst_done", int'(bus.done_o), 0);
        chk("mid_rst_aborted", int'(bus.aborted_o), 0);
        chk("mid_rst_stall", int'(bus.stall_cnt_o), 0);
        chk("mid_rst_herr", int'(bus.hold_err_o), 0);
        iss_q.delete();
        dat_q.delete();
        exp_done = -1;
        step();
        rst = 1'b0;
        step();
        chk("no_done_after_rst", done_cnt - d0, 0);
        // Clean window from base two cycles after the reset.
        run_window(2, 3, -1, 0, -1, 0, 0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
